// File: rtl/regfile_2r1w_pkg.sv
// Shared constants for the general-purpose register file: default geometry
// and the index of the hardwired zero register.
package regfile_2r1w_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int ZERO_IDX  = 0;

endpackage : regfile_2r1w_pkg

// File: rtl/regfile_byte_merge.sv
// Byte-wise merge of a stored word with write data under a byte mask.
// Shared by the write path and both bypass paths so they always agree.
module regfile_byte_merge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   stored,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  output logic [WIDTH-1:0]   merged
);

  // Take each byte from wr_data where its strobe is set, else keep the stored byte.
  always_comb begin
    // NOTE: assigning a full default before the conditional overrides means
    // every bit is written on every path, so no latch can be inferred.
    merged = stored;
    for (int i = 0; i < WIDTH / 8; i++) begin
      if (wr_be[i]) begin
        merged[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

endmodule : regfile_byte_merge

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with per-byte write strobes, an optional
// hardwired zero register and optional same-cycle write-to-read bypass.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  bit ZERO_REG = 1'b1,
  parameter  bit BYPASS   = 1'b1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_enable,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [AW-1:0]      rd_addr_a,
  output logic [WIDTH-1:0]   rd_data_a,
  input  logic [AW-1:0]      rd_addr_b,
  output logic [WIDTH-1:0]   rd_data_b
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] wr_sel;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] stored_a, stored_b;
  logic [WIDTH-1:0] merged_a, merged_b;
  logic             zero_a, zero_b;
  logic             hit_a, hit_b;

  // One-hot write decode; the zero register never receives a write.
  always_comb begin
    wr_sel = '0;
    if (wr_enable) begin
      wr_sel[wr_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      wr_sel[ZERO_IDX] = 1'b0;
    end
  end

  regfile_byte_merge #(.WIDTH(WIDTH)) u_wr_merge (
    .stored  (regs[wr_addr]),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .merged  (wr_merged)
  );

  // Register array: cleared on reset, otherwise the selected entry takes the merged word.
  always_ff @(posedge clk) begin
    // NOTE: this is a flop array, not a RAM macro, and every entry must read 0
    // after reset, so the whole array is cleared here; reset also wins over a
    // concurrent write.
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        // NOTE: non-blocking assignments for all clocked state, so every
        // register samples pre-edge values regardless of statement order.
        regs[i] <= '0;
      end else if (wr_sel[i]) begin
        regs[i] <= wr_merged;
      end
    end
  end

  // Read-side zero-register masking and bypass hit detection.
  always_comb begin
    zero_a   = ZERO_REG && (rd_addr_a == ZERO_ADDR);
    zero_b   = ZERO_REG && (rd_addr_b == ZERO_ADDR);
    stored_a = zero_a ? '0 : regs[rd_addr_a];
    stored_b = zero_b ? '0 : regs[rd_addr_b];
    hit_a    = BYPASS && wr_enable && (wr_addr == rd_addr_a) && !zero_a;
    hit_b    = BYPASS && wr_enable && (wr_addr == rd_addr_b) && !zero_b;
  end

  regfile_byte_merge #(.WIDTH(WIDTH)) u_byp_merge_a (
    .stored  (stored_a),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .merged  (merged_a)
  );

  regfile_byte_merge #(.WIDTH(WIDTH)) u_byp_merge_b (
    .stored  (stored_b),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .merged  (merged_b)
  );

  // Output select: forwarded write data on a bypass hit, stored value otherwise.
  always_comb begin
    rd_data_a = hit_a ? merged_a : stored_a;
    rd_data_b = hit_b ? merged_b : stored_b;
  end

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench: a bypassing and a non-bypassing register file share
// all stimulus and are compared against a behavioural array model.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_enable;
  logic [4:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [31:0] rd_a, rd_b, rd_a_nb, rd_b_nb;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rd_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_b)
  );

  regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rd_a_nb),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_b_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // What a read port should show right now, before the next edge.
  function automatic logic [31:0] expect_read(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (a == 5'd0) return 32'h0;
    v = mem[a];
    if (byp && wr_enable && wr_addr == a) v = merge(v, wr_data, wr_be);
    return v;
  endfunction

  task automatic drive(input logic rst, input logic en, input logic [4:0] wa,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clk);
    reset = rst; wr_enable = en; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
  endtask

  task automatic check_reads();
    check("byp_a",   rd_a,    expect_read(rd_addr_a, 1'b1));
    check("byp_b",   rd_b,    expect_read(rd_addr_b, 1'b1));
    check("nobyp_a", rd_a_nb, expect_read(rd_addr_a, 1'b0));
    check("nobyp_b", rd_b_nb, expect_read(rd_addr_b, 1'b0));
  endtask

  // Advance one edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else if (wr_enable && wr_addr != 5'd0) begin
      mem[wr_addr] = merge(mem[wr_addr], wr_data, wr_be);
    end
    #1;
  endtask

  task automatic step(input logic rst, input logic en, input logic [4:0] wa,
                      input logic [3:0] be, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb);
    drive(rst, en, wa, be, wd, ra, rb);
    #1;
    check_reads();
    tick();
  endtask

  task automatic sweep_zero();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'(i), 5'(31 - i));
      #1;
      check("rst_a", rd_a, 32'h0);
      check("rst_b", rd_b, 32'h0);
      check("rst_nb_a", rd_a_nb, 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    // Initial reset; nothing is defined before it, so no pre-edge check.
    drive(1'b1, 1'b0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd0);
    tick();
    sweep_zero();

    // Preload reg5, then reset with a concurrent write to reg5.
    step(1'b0, 1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 5'd5, 5'd5);
    drive(1'b1, 1'b1, 5'd5, 4'hF, 32'h00000001, 5'd5, 5'd0);
    #1;
    check_reads();
    check("rstcyc_byp_a", rd_a, 32'h00000001);
    check("rstcyc_nb_a", rd_a_nb, 32'hDEADBEEF);
    tick();
    sweep_zero();

    // Full write, then disabled write must not store.
    step(1'b0, 1'b1, 5'd7, 4'hF, 32'd88, 5'd7, 5'd7);
    step(1'b0, 1'b0, 5'd7, 4'hF, 32'd89, 5'd7, 5'd7);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd7, 5'd7);
    #1;
    check("r7_a", rd_a, 32'd88);
    check("r7_b", rd_b, 32'd88);

    // Byte mask.
    step(1'b0, 1'b1, 5'd3, 4'hF, 32'h11223344, 5'd3, 5'd7);
    step(1'b0, 1'b1, 5'd3, 4'b0101, 32'hAABBCCDD, 5'd3, 5'd3);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd3);
    #1;
    check("be_a", rd_a, 32'h11BB33DD);
    check("be_nb_b", rd_b_nb, 32'h11BB33DD);

    // Zero register, including the write cycle itself.
    drive(1'b0, 1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    check("z_wcyc_a", rd_a, 32'h0);
    check("z_wcyc_b", rd_b, 32'h0);
    tick();
    step(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd0);

    // Bypass versus no bypass.
    step(1'b0, 1'b1, 5'd9, 4'hF, 32'h0, 5'd9, 5'd9);
    drive(1'b0, 1'b1, 5'd9, 4'b0011, 32'h12345678, 5'd9, 5'd9);
    #1;
    check("byp9_a", rd_a, 32'h00005678);
    check("byp9_b", rd_b, 32'h00005678);
    check("nobyp9_a", rd_a_nb, 32'h00000000);
    tick();
    drive(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd9, 5'd9);
    #1;
    check("post9_a", rd_a, 32'h00005678);
    check("post9_nb_a", rd_a_nb, 32'h00005678);

    // Back-to-back writes, then sweep both ports.
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 5'(i), 4'hF, 32'(i * 3), 5'(i), 5'(i - 1));
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'(i), 5'(i));
      #1;
      check("b2b_a", rd_a, 32'(i * 3));
      check("b2b_nb_b", rd_b_nb, 32'(i * 3));
    end

    // Randomised traffic with occasional reset and forced address collisions.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa, ra, rb;
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 59) == 0), 1'($urandom), wa, 4'($urandom), $urandom, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_2r1w
